// File: rtl/adder_meter_pkg.sv
// Shared types and constants for the adder ring-oscillator measurement controller.
package adder_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_COUNT,
    ST_DONE
  } meter_state_t;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_BOTH = 1'b1;

endpackage

// File: rtl/ring_edge_sync.sv
// Brings the free-running ring output into the clock domain and flags its edges.
// At most one edge is reported per clock; faster ring activity aliases.
module ring_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ring_in,
  output logic rise,
  output logic any_edge
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   hist_reg;
  logic                   sync_out;

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // History follows the synchroniser every cycle, so it is already aligned
  // when counting begins and no stale edge leaks into the first COUNT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], ring_in};
      hist_reg <= sync_out;
    end
  end

  assign rise     = sync_out & ~hist_reg;
  assign any_edge = sync_out ^ hist_reg;

endmodule

// File: rtl/adder_ring_meter.sv
// Measurement controller: holds adder operands/tap selects, gates the ring
// oscillator and counts its transitions over a programmable clock window.
module adder_ring_meter
  import adder_meter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int COUNT_W     = 32,
  parameter int WINDOW_W    = 24,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                load,
  input  logic [WIDTH-1:0]    a_in,
  input  logic [WIDTH-1:0]    b_in,
  input  logic [WIDTH-1:0]    ring_sel_in,
  input  logic [WIDTH-1:0]    ext_sel_in,
  input  logic [WIDTH-1:0]    sum_sel_in,
  input  logic                start,
  input  logic                abort,
  input  logic                edge_mode,
  input  logic [WINDOW_W-1:0] window,
  input  logic                ring_in,
  output logic [WIDTH-1:0]    a_input,
  output logic [WIDTH-1:0]    b_input,
  output logic [WIDTH-1:0]    a_ring_bit_b,
  output logic [WIDTH-1:0]    a_ext_bit_b,
  output logic [WIDTH-1:0]    s_output_bit_b,
  output logic                ring_en,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [COUNT_W-1:0]  count
);

  localparam int                 ARM_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ARM_W-1:0]   ARM_LOAD  = ARM_W'(SETTLE - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  meter_state_t        state_reg;
  logic [ARM_W-1:0]    arm_cnt_reg;
  logic [WINDOW_W-1:0] win_cnt_reg;
  logic                edge_mode_reg;
  logic                ring_en_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                overflow_reg;
  logic [COUNT_W-1:0]  count_reg;

  logic [WIDTH-1:0] a_reg, b_reg, ring_sel_reg, ext_sel_reg, sum_sel_reg;

  logic rise, any_edge, edge_hit, idle_or_done;

  ring_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n),
    .ring_in  (ring_in),
    .rise     (rise),
    .any_edge (any_edge)
  );

  assign idle_or_done = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign edge_hit     = (edge_mode_reg == EDGE_BOTH) ? any_edge : rise;

  // Operands stay frozen while the ring is running.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      ring_sel_reg <= '0;
      ext_sel_reg  <= '0;
      sum_sel_reg  <= '0;
    end else if (load && idle_or_done) begin
      a_reg        <= a_in;
      b_reg        <= b_in;
      ring_sel_reg <= ring_sel_in;
      ext_sel_reg  <= ext_sel_in;
      sum_sel_reg  <= sum_sel_in;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg     <= ST_IDLE;
      arm_cnt_reg   <= '0;
      win_cnt_reg   <= '0;
      edge_mode_reg <= EDGE_RISE;
      ring_en_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      count_reg     <= '0;
    end else if (abort) begin
      state_reg    <= ST_IDLE;
      ring_en_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            if (window == '0) begin
              state_reg   <= ST_DONE;
              done_reg    <= 1'b1;
              ring_en_reg <= 1'b0;
              busy_reg    <= 1'b0;
            end else begin
              state_reg     <= ST_ARM;
              arm_cnt_reg   <= ARM_LOAD;
              win_cnt_reg   <= window - 1'b1;
              edge_mode_reg <= edge_mode;
              done_reg      <= 1'b0;
              ring_en_reg   <= 1'b1;
              busy_reg      <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (arm_cnt_reg == '0) begin
            state_reg <= ST_COUNT;
          end else begin
            arm_cnt_reg <= arm_cnt_reg - 1'b1;
          end
        end
        ST_COUNT: begin
          if (edge_hit) begin
            if (count_reg == COUNT_MAX) begin
              overflow_reg <= 1'b1;
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
          if (win_cnt_reg == '0) begin
            state_reg   <= ST_DONE;
            ring_en_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
          end else begin
            win_cnt_reg <= win_cnt_reg - 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign a_input        = a_reg;
  assign b_input        = b_reg;
  assign a_ring_bit_b   = ring_sel_reg;
  assign a_ext_bit_b    = ext_sel_reg;
  assign s_output_bit_b = sum_sel_reg;
  assign ring_en        = ring_en_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign overflow       = overflow_reg;
  assign count          = count_reg;

endmodule

// File: tb/tb_adder_ring_meter.sv
// Self-checking bench: a 32-bit-count meter and a 4-bit-count meter share stimulus;
// expected results are queued at start and compared when done rises.
module tb_adder_ring_meter;

  localparam int WIDTH    = 32;
  localparam int WINDOW_W = 24;
  localparam int SETTLE   = 4;

  typedef struct packed {
    logic [31:0] cnt;
    logic        ovf;
    logic [3:0]  cnt_s;
    logic        ovf_s;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                load = 1'b0;
  logic [WIDTH-1:0]    a_in = '0, b_in = '0, ring_sel_in = '0, ext_sel_in = '0, sum_sel_in = '0;
  logic                start = 1'b0, abort = 1'b0, edge_mode = 1'b0;
  logic [WINDOW_W-1:0] window = '0;
  logic                ring_in = 1'b0;

  logic [WIDTH-1:0] a_input, b_input, a_ring_bit_b, a_ext_bit_b, s_output_bit_b;
  logic             ring_en, busy, done, overflow;
  logic [31:0]      count;

  logic [WIDTH-1:0] a_input_s, b_input_s, a_ring_bit_b_s, a_ext_bit_b_s, s_output_bit_b_s;
  logic             ring_en_s, busy_s, done_s, overflow_s;
  logic [3:0]       count_s;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ring_mode = 0;
  int   phase = 0;

  always #5 clk = ~clk;

  adder_ring_meter #(
    .WIDTH(WIDTH), .COUNT_W(32), .WINDOW_W(WINDOW_W), .SYNC_STAGES(2), .SETTLE(SETTLE)
  ) u_dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .load(load), .a_in(a_in), .b_in(b_in),
    .ring_sel_in(ring_sel_in), .ext_sel_in(ext_sel_in), .sum_sel_in(sum_sel_in),
    .start(start), .abort(abort), .edge_mode(edge_mode), .window(window), .ring_in(ring_in),
    .a_input(a_input), .b_input(b_input), .a_ring_bit_b(a_ring_bit_b),
    .a_ext_bit_b(a_ext_bit_b), .s_output_bit_b(s_output_bit_b), .ring_en(ring_en),
    .busy(busy), .done(done), .overflow(overflow), .count(count)
  );

  adder_ring_meter #(
    .WIDTH(WIDTH), .COUNT_W(4), .WINDOW_W(WINDOW_W), .SYNC_STAGES(2), .SETTLE(SETTLE)
  ) u_dut_sat (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .load(load), .a_in(a_in), .b_in(b_in),
    .ring_sel_in(ring_sel_in), .ext_sel_in(ext_sel_in), .sum_sel_in(sum_sel_in),
    .start(start), .abort(abort), .edge_mode(edge_mode), .window(window), .ring_in(ring_in),
    .a_input(a_input_s), .b_input(b_input_s), .a_ring_bit_b(a_ring_bit_b_s),
    .a_ext_bit_b(a_ext_bit_b_s), .s_output_bit_b(s_output_bit_b_s), .ring_en(ring_en_s),
    .busy(busy_s), .done(done_s), .overflow(overflow_s), .count(count_s)
  );

  // Ring stimulus: 0 = quiet, 1 = clk/4 square wave, 2 = toggle every cycle.
  initial begin
    forever begin
      @(negedge clk);
      phase++;
      case (ring_mode)
        1: if (phase % 2 == 0) ring_in = ~ring_in;
        2: ring_in = ~ring_in;
        default: ring_in = 1'b0;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Latency is counted in clock edges, the edge that samples start being edge 1;
  // done shows up after edge 1+SETTLE+window, i.e. in the (2+SETTLE+window)th cycle
  // counting the start cycle as the first.
  task automatic measure(input string name, input logic [WINDOW_W-1:0] win, input logic mode,
                         input int rmode, input logic do_load, input exp_t e);
    int   cyc;
    int   en_cyc;
    int   exp_lat;
    exp_t want;
    exp_q.push_back(e);
    ring_mode = rmode;
    @(negedge clk);
    window = win; edge_mode = mode; start = 1'b1; load = do_load;
    @(negedge clk);
    start = 1'b0; load = 1'b0;
    cyc = 1; en_cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      if (ring_en === 1'b1) en_cyc++;
      @(negedge clk);
      cyc++;
    end
    exp_lat = (win == 0) ? 1 : 1 + SETTLE + int'(win);
    want = exp_q.pop_front();
    check_eq({name, "_done_lat"}, 64'(cyc), 64'(exp_lat));
    check_eq({name, "_en_cycles"}, 64'(en_cyc), 64'((win == 0) ? 0 : SETTLE + int'(win)));
    check_eq({name, "_en_off"}, 64'(ring_en), 64'(0));
    check_eq({name, "_busy_off"}, 64'(busy), 64'(0));
    check_eq({name, "_count"}, 64'(count), 64'(want.cnt));
    check_eq({name, "_ovf"}, 64'(overflow), 64'(want.ovf));
    check_eq({name, "_count4"}, 64'(count_s), 64'(want.cnt_s));
    check_eq({name, "_ovf4"}, 64'(overflow_s), 64'(want.ovf_s));
    $display("meas %s: window=%0d mode=%0d count=%0d ovf=%0d count4=%0d ovf4=%0d latency=%0d",
             name, win, mode, count, overflow, count_s, overflow_s, cyc);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_a_input", 64'(a_input), 64'(0));
    check_eq("rst_ctrl", {60'd0, ring_en, busy, done, overflow}, 64'(0));
    check_eq("rst_count", 64'(count), 64'(0));
    rst_n = 1'b1;
    $display("reset released");

    @(negedge clk);
    a_in = 32'h0000_0001; ring_sel_in = 32'h0800_0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check_eq("load_a", 64'(a_input), 64'h1);
    check_eq("load_ring_sel", 64'(a_ring_bit_b), 64'h0800_0000);
    check_eq("load_others", {a_ext_bit_b, s_output_bit_b} | 64'(b_input), 64'(0));
    check_eq("load_ctrl", {60'd0, ring_en, busy, done, overflow}, 64'(0));
    $display("load: a_input=0x%08h a_ring_bit_b=0x%08h", a_input, a_ring_bit_b);

    measure("rise100", 24'd100, 1'b0, 1, 1'b0, '{cnt: 32'd25, ovf: 1'b0, cnt_s: 4'd15, ovf_s: 1'b1});
    measure("both100", 24'd100, 1'b1, 1, 1'b0, '{cnt: 32'd50, ovf: 1'b0, cnt_s: 4'd15, ovf_s: 1'b1});
    measure("sat64",   24'd64,  1'b1, 2, 1'b0, '{cnt: 32'd64, ovf: 1'b0, cnt_s: 4'd15, ovf_s: 1'b1});

    // Abort in the 10th COUNT cycle with a competing start; a load mid-COUNT is ignored.
    ring_mode = 1;
    @(negedge clk);
    window = 24'd100; edge_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < SETTLE + 10; i++) begin
      if (i == SETTLE + 5) begin
        a_in = 32'hDEAD_BEEF; load = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
    end
    check_eq("abort_pre_busy", 64'(busy), 64'(1));
    check_eq("load_in_count", 64'(a_input), 64'h1);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check_eq("abort_ctrl", {60'd0, ring_en, busy, done, overflow}, 64'(0));
    check_eq("abort_count", 64'(count), 64'(0));
    check_eq("abort_count4", 64'(count_s), 64'(0));
    repeat (3) @(negedge clk);
    check_eq("abort_start_ignored", {62'd0, ring_en, busy}, 64'(0));
    $display("abort: ring_en=%0d busy=%0d done=%0d count=%0d", ring_en, busy, done, count);

    // Zero window, with a load in the same cycle as start.
    a_in = 32'h0000_00A5;
    measure("win0", 24'd0, 1'b0, 1, 1'b1, '{cnt: 32'd0, ovf: 1'b0, cnt_s: 4'd0, ovf_s: 1'b0});
    check_eq("win0_done", 64'(done), 64'(1));
    check_eq("load_with_start", 64'(a_input), 64'hA5);

    // Asynchronous reset in the middle of COUNT.
    @(negedge clk);
    window = 24'd100; edge_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE + 5) @(negedge clk);
    check_eq("pre_rst_en", 64'(ring_en), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_ctrl", {60'd0, ring_en, busy, done, overflow}, 64'(0));
    check_eq("async_rst_a", 64'(a_input), 64'(0));
    check_eq("async_rst_count", 64'(count), 64'(0));
    $display("async reset: ring_en=%0d a_input=0x%08h count=%0d", ring_en, a_input, count);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_ring_meter.md
Name: adder_ring_meter

Overview:
- Parametrised measurement controller for instrumented adder experiments.
- Holds adder operands and per-bit ring/external/sum tap selects, and gates the ring-oscillator enable.
- Counts ring-oscillator transitions (chain_out, asynchronous) over a programmable window of wb_clk_i cycles, and reports a saturating count.
- Sits between the wrapper's logic-analyser/IO registers and the adder-under-test.
- Generalises the fixed 32-bit single-shot arrangement with:
  - configurable width;
  - selectable edge mode;
  - abort;
  - overflow flag.

Parameters:
- WIDTH, 32, adder operand width and width of each tap-select mask.
- COUNT_W, 32, ring transition counter width.
- WINDOW_W, 24, measurement window length width, in clock cycles.
- SYNC_STAGES, 2, synchroniser depth for ring_in (minimum 2).
- SETTLE, 4, cycles between ring enable and start of counting (minimum 1).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_n  in  1  asynchronous active-low reset
- load  in  1  capture operands and selects (single-cycle pulse)
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- ring_sel_in  in  WIDTH  bits of A driven from the ring loop
- ext_sel_in  in  WIDTH  bits of A driven externally
- sum_sel_in  in  WIDTH  sum bits fed back into the chain
- start  in  1  begin measurement (single-cycle pulse)
- abort  in  1  cancel measurement
- edge_mode  in  1  0 = count rising edges, 1 = count both edges (sampled at start)
- window  in  WINDOW_W  counting window length, in cycles (sampled at start)
- ring_in  in  1  chain_out from the adder ring; asynchronous to wb_clk_i
- a_input  out  WIDTH  registered operand A
- b_input  out  WIDTH  registered operand B
- a_ring_bit_b  out  WIDTH  registered ring select
- a_ext_bit_b  out  WIDTH  registered external select
- s_output_bit_b  out  WIDTH  registered sum select
- ring_en  out  1  oscillator enable
- busy  out  1  high in ARM or COUNT
- done  out  1  result valid
- overflow  out  1  count saturated
- count  out  COUNT_W  transition count

Behaviour:
- Reset (asynchronous, wb_rst_n low):
  - all outputs 0;
  - synchroniser flops 0;
  - FSM in IDLE.
- Reset mid-measurement drops ring_en immediately.
- States: IDLE, ARM, COUNT, DONE.
- load:
  - accepted only in IDLE or DONE;
  - the five registered vectors update on the next edge;
  - ignored in ARM or COUNT.
- start, accepted in IDLE or DONE:
  - window == 0 → go to DONE next cycle; count = 0, overflow = 0, done = 1; ring_en stays 0.
  - otherwise:
    - latch window and edge_mode;
    - clear count, overflow and done;
    - set ring_en = 1 and busy = 1;
    - go to ARM.
- start is ignored in ARM and COUNT.
- load and start in the same cycle: both take effect; the operands update on the same edge that raises ring_en.
- ARM:
  - lasts exactly SETTLE cycles; no counting;
  - the edge detector's history flop is loaded from the synchroniser output on every ARM cycle, so no spurious edge is seen on entry to COUNT.
- COUNT:
  - lasts exactly window cycles;
  - each cycle, if a qualifying edge of the synchronised ring_in is seen, count += 1;
  - at the all-ones value, count holds and overflow is set (sticky until the next start).
- Leaving COUNT:
  - next cycle enters DONE;
  - ring_en = 0, busy = 0, done = 1;
  - count is frozen.
- DONE persists until the next accepted start, or until abort.
- abort, from any state: next cycle IDLE, ring_en = 0, busy = 0, done = 0; count and overflow are cleared.
- abort wins over a simultaneous start.
- Edge counting:
  - edge_mode = 0 counts 0→1 transitions only;
  - edge_mode = 1 counts every transition;
  - at most one increment per clock (aliasing above fclk/2 is accepted and documented).
- Latency from ring_in transition to count increment: SYNC_STAGES + 1 cycles.

Decomposition:
- Package adder_meter_pkg holds:
  - the FSM state enum (meter_state_t);
  - the edge mode constants EDGE_RISE and EDGE_BOTH.
- One sub-module: ring_edge_sync, containing:
  - the parametrised SYNC_STAGES synchroniser;
  - the history flop;
  - rise/any-edge outputs.

Test Plan:
- Reset release, then load with a_in = 0x0000_0001, ring_sel_in = 0x0800_0000 → a_input = 0x1 and a_ring_bit_b = 0x0800_0000 one cycle later; all other outputs 0.
- start with window = 100, edge_mode = 0, ring_in a clock/4 square wave:
  - count = 25 (±1);
  - done rises exactly 1 + SETTLE + 100 + 1 cycles after start;
  - ring_en is high only during ARM/COUNT.
- Same stimulus with edge_mode = 1 → count = 50 (±1).
- COUNT_W = 4, window = 64, ring_in toggling every cycle with edge_mode = 1 → count = 15, overflow = 1.
- abort in the 10th COUNT cycle → IDLE next cycle; ring_en = 0, done = 0, count = 0. A start in the same cycle as abort is ignored.
- start with window = 0 → done = 1 after 1 cycle, count = 0, ring_en never asserted. load during COUNT leaves a_input unchanged. wb_rst_n low mid-COUNT → all outputs 0 asynchronously.
